// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and load/store, data first.
// Define MEM_ARB_IBUF_EN to add a one-entry fetch buffer that skips the bus on a repeat fetch.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_rdata_o,
  output logic              inst_ok_o,
  input  logic              data_req_i,
  input  logic [3:0]        data_wen_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_ok_o,
  output logic              mem_req_o,
  output logic [3:0]        mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o
);

  typedef enum logic [2:0] {IDLE, D_BUSY, I_BUSY, D_DONE, I_DONE} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [3:0]        mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              cancel_q, cancel_d;
  logic              ibuf_hit;

`ifdef MEM_ARB_IBUF_EN
  logic              ibuf_valid_q, ibuf_valid_d;
  logic [ADDR_W-1:0] ibuf_tag_q, ibuf_tag_d;
  logic [DATA_W-1:0] ibuf_word_q, ibuf_word_d;
  assign ibuf_hit = ibuf_valid_q && (inst_addr_i == ibuf_tag_q);
`else
  assign ibuf_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (data_req_i)      state_d = D_BUSY;
        else if (inst_req_i) state_d = ibuf_hit ? I_DONE : I_BUSY;
      end
      D_BUSY:  if (mem_ack_i) state_d = D_DONE;
      I_BUSY:  if (mem_ack_i) state_d = I_DONE;
      D_DONE:  state_d = IDLE;
      I_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_ok_o = (state_q == D_DONE);
    inst_ok_o = (state_q == I_DONE) && !cancel_q;
  end

  // Bus fields are latched once on grant and held until the ack; read data only lands on live requests.
  always_comb begin
    mem_req_d    = (state_d == D_BUSY) || (state_d == I_BUSY);
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    cancel_d     = cancel_q;
`ifdef MEM_ARB_IBUF_EN
    ibuf_valid_d = ibuf_valid_q;
    ibuf_tag_d   = ibuf_tag_q;
    ibuf_word_d  = ibuf_word_q;
`endif
    case (state_q)
      IDLE: begin
        if (data_req_i) begin
          mem_wen_d   = data_wen_i;
          mem_addr_d  = data_addr_i;
          mem_wdata_d = data_wdata_i;
        end else if (inst_req_i) begin
`ifdef MEM_ARB_IBUF_EN
          if (ibuf_hit) begin
            inst_rdata_d = ibuf_word_q;
          end else begin
            mem_wen_d  = 4'b0000;
            mem_addr_d = inst_addr_i;
          end
`else
          mem_wen_d  = 4'b0000;
          mem_addr_d = inst_addr_i;
`endif
        end
      end
      D_BUSY: begin
        if (mem_ack_i && (mem_wen_q == 4'b0000)) data_rdata_d = mem_rdata_i;
      end
      I_BUSY: begin
        if (!inst_req_i) cancel_d = 1'b1;
        if (mem_ack_i && inst_req_i && !cancel_q) begin
          inst_rdata_d = mem_rdata_i;
`ifdef MEM_ARB_IBUF_EN
          ibuf_valid_d = 1'b1;
          ibuf_tag_d   = mem_addr_q;
          ibuf_word_d  = mem_rdata_i;
`endif
        end
      end
`ifdef MEM_ARB_IBUF_EN
      // A store to the buffered word makes the cached instruction stale.
      D_DONE: begin
        if ((mem_wen_q != 4'b0000) && (mem_addr_q[ADDR_W-1:2] == ibuf_tag_q[ADDR_W-1:2]))
          ibuf_valid_d = 1'b0;
      end
`endif
      default: ;
    endcase
    if (state_d == IDLE) cancel_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mem_req_q    <= 1'b0;
      mem_wen_q    <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      cancel_q     <= 1'b0;
`ifdef MEM_ARB_IBUF_EN
      ibuf_valid_q <= 1'b0;
      ibuf_tag_q   <= '0;
      ibuf_word_q  <= '0;
`endif
    end else begin
      mem_req_q    <= mem_req_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      cancel_q     <= cancel_d;
`ifdef MEM_ARB_IBUF_EN
      ibuf_valid_q <= ibuf_valid_d;
      ibuf_tag_q   <= ibuf_tag_d;
      ibuf_word_q  <= ibuf_word_d;
`endif
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_wen_o    = mem_wen_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign inst_rdata_o = inst_rdata_q;
  assign data_rdata_o = data_rdata_q;
  assign stall_o      = (inst_req_i & ~inst_ok_o) | (data_req_i & ~data_ok_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a simple acking memory responder.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_i;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata_o;
  logic        inst_ok_o;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata_o;
  logic        data_ok_o;
  logic        mem_req_o;
  logic [3:0]  mem_wen_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_o;

  int assertCount = 0;
  int failCount   = 0;
  int ackWait     = 0;
  int waitCnt     = 0;
  logic [31:0] respData = 32'h0;
  logic [31:0] busAddrLog[$];
  logic [3:0]  busWenLog[$];
  logic [31:0] busWdataLog[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_rdata_o(inst_rdata_o), .inst_ok_o(inst_ok_o),
    .data_req_i(data_req), .data_wen_i(data_wen), .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_rdata_o(data_rdata_o), .data_ok_o(data_ok_o),
    .mem_req_o(mem_req_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .stall_o(stall_o)
  );

  // Memory responder: acks after ackWait extra cycles of mem_req and logs each bus transaction.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req_o) begin
        if (waitCnt >= ackWait) begin
          mem_ack   = 1'b1;
          mem_rdata = respData;
          busAddrLog.push_back(mem_addr_o);
          busWenLog.push_back(mem_wen_o);
          busWdataLog.push_back(mem_wdata_o);
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Waits for the selected ok pulse, dropping that request when it arrives; lat is -1 on timeout.
  task automatic waitOk(input bit isData, input int maxCyc, output int lat);
    lat = -1;
    for (int i = 1; i <= maxCyc; i++) begin
      tick();
      if (isData ? data_ok_o : inst_ok_o) begin
        lat = i;
        break;
      end
    end
    if (isData) data_req = 1'b0;
    else        inst_req = 1'b0;
  endtask

  task automatic clearLog();
    busAddrLog.delete();
    busWenLog.delete();
    busWdataLog.delete();
  endtask

  task automatic test_reset();
    rst_i = 1'b0; inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0;
    data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    tick(); tick();
    assertCount++; if (mem_req_o !== 1'b0)     begin failCount++; $display("[TB] FAIL rst_mem_req: got %0b expected 0", mem_req_o); end
    assertCount++; if (mem_wen_o !== 4'h0)     begin failCount++; $display("[TB] FAIL rst_mem_wen: got %h expected 0", mem_wen_o); end
    assertCount++; if (mem_addr_o !== 32'h0)   begin failCount++; $display("[TB] FAIL rst_mem_addr: got %h expected 0", mem_addr_o); end
    assertCount++; if (mem_wdata_o !== 32'h0)  begin failCount++; $display("[TB] FAIL rst_mem_wdata: got %h expected 0", mem_wdata_o); end
    assertCount++; if (inst_ok_o !== 1'b0)     begin failCount++; $display("[TB] FAIL rst_inst_ok: got %0b expected 0", inst_ok_o); end
    assertCount++; if (data_ok_o !== 1'b0)     begin failCount++; $display("[TB] FAIL rst_data_ok: got %0b expected 0", data_ok_o); end
    assertCount++; if (inst_rdata_o !== 32'h0) begin failCount++; $display("[TB] FAIL rst_inst_rdata: got %h expected 0", inst_rdata_o); end
    assertCount++; if (data_rdata_o !== 32'h0) begin failCount++; $display("[TB] FAIL rst_data_rdata: got %h expected 0", data_rdata_o); end
    assertCount++; if (stall_o !== 1'b0)       begin failCount++; $display("[TB] FAIL rst_stall: got %0b expected 0", stall_o); end
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_load();
    ackWait = 0; respData = 32'hDEADBEEF;
    data_wen = 4'h0; data_addr = 32'h100; data_req = 1'b1;
    #1;
    assertCount++; if (stall_o !== 1'b1) begin failCount++; $display("[TB] FAIL load_stall_req: got %0b expected 1", stall_o); end
    tick();
    assertCount++; if (mem_req_o !== 1'b1)     begin failCount++; $display("[TB] FAIL load_mem_req: got %0b expected 1", mem_req_o); end
    assertCount++; if (mem_addr_o !== 32'h100) begin failCount++; $display("[TB] FAIL load_mem_addr: got %h expected 100", mem_addr_o); end
    assertCount++; if (mem_wen_o !== 4'h0)     begin failCount++; $display("[TB] FAIL load_mem_wen: got %h expected 0", mem_wen_o); end
    assertCount++; if (data_ok_o !== 1'b0)     begin failCount++; $display("[TB] FAIL load_ok_early: got %0b expected 0", data_ok_o); end
    assertCount++; if (stall_o !== 1'b1)       begin failCount++; $display("[TB] FAIL load_stall_busy: got %0b expected 1", stall_o); end
    tick();
    assertCount++; if (data_ok_o !== 1'b1)            begin failCount++; $display("[TB] FAIL load_ok: got %0b expected 1", data_ok_o); end
    assertCount++; if (data_rdata_o !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL load_rdata: got %h expected deadbeef", data_rdata_o); end
    assertCount++; if (stall_o !== 1'b0)              begin failCount++; $display("[TB] FAIL load_stall_ok: got %0b expected 0", stall_o); end
    data_req = 1'b0;
    tick();
    assertCount++; if (data_ok_o !== 1'b0) begin failCount++; $display("[TB] FAIL load_ok_pulse: got %0b expected 0", data_ok_o); end
    assertCount++; if (mem_req_o !== 1'b0) begin failCount++; $display("[TB] FAIL load_mem_req_off: got %0b expected 0", mem_req_o); end
    tick();
  endtask

  task automatic test_priority();
    ackWait = 0; respData = 32'h24020005; clearLog();
    inst_addr = 32'h0; inst_req = 1'b1;
    data_wen = 4'b0001; data_addr = 32'h200; data_wdata = 32'h55; data_req = 1'b1;
    tick();
    assertCount++; if (mem_wen_o !== 4'b0001)  begin failCount++; $display("[TB] FAIL prio_first_wen: got %h expected 1", mem_wen_o); end
    assertCount++; if (mem_addr_o !== 32'h200) begin failCount++; $display("[TB] FAIL prio_first_addr: got %h expected 200", mem_addr_o); end
    assertCount++; if (mem_wdata_o !== 32'h55) begin failCount++; $display("[TB] FAIL prio_first_wdata: got %h expected 55", mem_wdata_o); end
    tick();
    assertCount++; if (data_ok_o !== 1'b1)            begin failCount++; $display("[TB] FAIL prio_data_ok: got %0b expected 1", data_ok_o); end
    assertCount++; if (inst_ok_o !== 1'b0)            begin failCount++; $display("[TB] FAIL prio_inst_early: got %0b expected 0", inst_ok_o); end
    assertCount++; if (data_rdata_o !== 32'hDEADBEEF) begin failCount++; $display("[TB] FAIL prio_store_rdata: got %h expected deadbeef", data_rdata_o); end
    data_req = 1'b0;
    tick();
    assertCount++; if (mem_req_o !== 1'b0) begin failCount++; $display("[TB] FAIL prio_gap_mem_req: got %0b expected 0", mem_req_o); end
    assertCount++; if (stall_o !== 1'b1)   begin failCount++; $display("[TB] FAIL prio_gap_stall: got %0b expected 1", stall_o); end
    tick();
    assertCount++; if (mem_req_o !== 1'b1)   begin failCount++; $display("[TB] FAIL prio_fetch_req: got %0b expected 1", mem_req_o); end
    assertCount++; if (mem_addr_o !== 32'h0) begin failCount++; $display("[TB] FAIL prio_fetch_addr: got %h expected 0", mem_addr_o); end
    assertCount++; if (mem_wen_o !== 4'h0)   begin failCount++; $display("[TB] FAIL prio_fetch_wen: got %h expected 0", mem_wen_o); end
    tick();
    assertCount++; if (inst_ok_o !== 1'b1)            begin failCount++; $display("[TB] FAIL prio_inst_ok: got %0b expected 1", inst_ok_o); end
    assertCount++; if (inst_rdata_o !== 32'h24020005) begin failCount++; $display("[TB] FAIL prio_inst_rdata: got %h expected 24020005", inst_rdata_o); end
    inst_req = 1'b0;
    assertCount++; if (busAddrLog.size() !== 2) begin failCount++; $display("[TB] FAIL prio_bus_count: got %0d expected 2", busAddrLog.size()); end
    tick(); tick();
  endtask

  task automatic test_fetch_cancel();
    int okSeen = 0;
    int lat;
    ackWait = 3; respData = 32'hBADBAD00; clearLog();
    inst_addr = 32'h40; inst_req = 1'b1;
    tick();
    assertCount++; if (mem_addr_o !== 32'h40) begin failCount++; $display("[TB] FAIL cancel_addr: got %h expected 40", mem_addr_o); end
    tick();
    inst_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (inst_ok_o) okSeen++;
    end
    assertCount++; if (okSeen !== 0)                  begin failCount++; $display("[TB] FAIL cancel_no_ok: got %0d pulses expected 0", okSeen); end
    assertCount++; if (busAddrLog.size() !== 1)       begin failCount++; $display("[TB] FAIL cancel_bus_done: got %0d expected 1", busAddrLog.size()); end
    assertCount++; if (inst_rdata_o !== 32'h24020005) begin failCount++; $display("[TB] FAIL cancel_rdata: got %h expected 24020005", inst_rdata_o); end
    assertCount++; if (mem_req_o !== 1'b0)            begin failCount++; $display("[TB] FAIL cancel_mem_req: got %0b expected 0", mem_req_o); end
    ackWait = 0; respData = 32'h8C820000;
    inst_addr = 32'h80; inst_req = 1'b1;
    waitOk(1'b0, 10, lat);
    assertCount++; if (lat !== 2)                     begin failCount++; $display("[TB] FAIL refetch_latency: got %0d expected 2", lat); end
    assertCount++; if (inst_rdata_o !== 32'h8C820000) begin failCount++; $display("[TB] FAIL refetch_rdata: got %h expected 8c820000", inst_rdata_o); end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    ackWait = 10; clearLog();
    data_wen = 4'h0; data_addr = 32'h300; data_req = 1'b1;
    tick();
    assertCount++; if (mem_req_o !== 1'b1) begin failCount++; $display("[TB] FAIL rstmid_busy: got %0b expected 1", mem_req_o); end
    rst_i = 1'b0;
    tick();
    assertCount++; if (mem_req_o !== 1'b0)     begin failCount++; $display("[TB] FAIL rstmid_mem_req: got %0b expected 0", mem_req_o); end
    assertCount++; if (mem_addr_o !== 32'h0)   begin failCount++; $display("[TB] FAIL rstmid_mem_addr: got %h expected 0", mem_addr_o); end
    assertCount++; if (data_rdata_o !== 32'h0) begin failCount++; $display("[TB] FAIL rstmid_data_rdata: got %h expected 0", data_rdata_o); end
    assertCount++; if (inst_rdata_o !== 32'h0) begin failCount++; $display("[TB] FAIL rstmid_inst_rdata: got %h expected 0", inst_rdata_o); end
    assertCount++; if (data_ok_o !== 1'b0)     begin failCount++; $display("[TB] FAIL rstmid_data_ok: got %0b expected 0", data_ok_o); end
    rst_i = 1'b1; ackWait = 0; respData = 32'h12345678;
    waitOk(1'b1, 10, lat);
    assertCount++; if (lat !== 2)                     begin failCount++; $display("[TB] FAIL rstmid_load_latency: got %0d expected 2", lat); end
    assertCount++; if (data_rdata_o !== 32'h12345678) begin failCount++; $display("[TB] FAIL rstmid_load_rdata: got %h expected 12345678", data_rdata_o); end
    assertCount++; if (busAddrLog.size() !== 1)       begin failCount++; $display("[TB] FAIL rstmid_bus_count: got %0d expected 1", busAddrLog.size()); end
    tick(); tick();
  endtask

  task automatic test_store();
    int lat;
    ackWait = 1; respData = 32'h0BADF00D; clearLog();
    data_wen = 4'hF; data_addr = 32'h104; data_wdata = 32'hCAFEF00D; data_req = 1'b1;
    waitOk(1'b1, 10, lat);
    assertCount++; if (lat !== 3)                     begin failCount++; $display("[TB] FAIL store_latency: got %0d expected 3", lat); end
    assertCount++; if (data_rdata_o !== 32'h12345678) begin failCount++; $display("[TB] FAIL store_rdata_kept: got %h expected 12345678", data_rdata_o); end
    assertCount++; if (busWdataLog.size() !== 1)      begin failCount++; $display("[TB] FAIL store_bus_count: got %0d expected 1", busWdataLog.size()); end
    if (busWdataLog.size() > 0) begin
      assertCount++; if (busWdataLog[0] !== 32'hCAFEF00D) begin failCount++; $display("[TB] FAIL store_wdata: got %h expected cafef00d", busWdataLog[0]); end
      assertCount++; if (busWenLog[0] !== 4'hF)           begin failCount++; $display("[TB] FAIL store_wen: got %h expected f", busWenLog[0]); end
    end
    tick(); tick();
  endtask

`ifdef MEM_ARB_IBUF_EN
  task automatic test_ibuf();
    int lat;
    ackWait = 0; respData = 32'h11111111; clearLog();
    inst_addr = 32'h10; inst_req = 1'b1;
    waitOk(1'b0, 10, lat);
    assertCount++; if (lat !== 2) begin failCount++; $display("[TB] FAIL ibuf_fill_latency: got %0d expected 2", lat); end
    tick(); clearLog();
    inst_req = 1'b1;
    waitOk(1'b0, 10, lat);
    assertCount++; if (lat !== 1)                     begin failCount++; $display("[TB] FAIL ibuf_hit_latency: got %0d expected 1", lat); end
    assertCount++; if (busAddrLog.size() !== 0)       begin failCount++; $display("[TB] FAIL ibuf_hit_bus: got %0d expected 0", busAddrLog.size()); end
    assertCount++; if (inst_rdata_o !== 32'h11111111) begin failCount++; $display("[TB] FAIL ibuf_hit_rdata: got %h expected 11111111", inst_rdata_o); end
    tick();
    data_wen = 4'hF; data_addr = 32'h10; data_wdata = 32'h0; data_req = 1'b1;
    waitOk(1'b1, 10, lat);
    tick(); clearLog();
    respData = 32'h22222222; inst_req = 1'b1;
    waitOk(1'b0, 10, lat);
    assertCount++; if (lat !== 2)                     begin failCount++; $display("[TB] FAIL ibuf_inval_latency: got %0d expected 2", lat); end
    assertCount++; if (busAddrLog.size() !== 1)       begin failCount++; $display("[TB] FAIL ibuf_inval_bus: got %0d expected 1", busAddrLog.size()); end
    assertCount++; if (inst_rdata_o !== 32'h22222222) begin failCount++; $display("[TB] FAIL ibuf_inval_rdata: got %h expected 22222222", inst_rdata_o); end
    tick(); tick();
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_priority();
    test_fetch_cancel();
    test_reset_mid();
    test_store();
`ifdef MEM_ARB_IBUF_EN
    test_ibuf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
